// File: rtl/ins_prefetch.sv
// Instruction prefetch queue between ifetch and the bus arbiter instruction port.
// Issues pipelined Wishbone reads at sequential word addresses, buffers the
// returned words with their byte addresses, and flushes on a PC redirect.
// Acks for requests issued before a redirect are counted in discard and dropped.
module ins_prefetch #(
  parameter int DEPTH  = 4,
  parameter int AWIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pc_set_i,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [31:0]       word_o,
  output logic [AWIDTH-1:0] word_adr_o,
  output logic              bus_cyc_o,
  output logic              bus_stb_o,
  output logic [AWIDTH-1:0] bus_adr_o,
  input  logic [31:0]       bus_dat_i,
  input  logic              bus_ack_i,
  input  logic              bus_stall_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [PW-1:0]     PTR_ONE  = PW'(1);
  localparam logic [CW:0]       DEPTH_W  = (CW+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] ADR_STEP = AWIDTH'(4);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] fetch_adr_q, fetch_adr_d;
  logic [AWIDTH-1:0] tail_adr_q, tail_adr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic              stb_q, stb_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [31:0]       data_q [DEPTH];
  logic [31:0]       data_d [DEPTH];
  logic [AWIDTH-1:0] adr_q [DEPTH];
  logic [AWIDTH-1:0] adr_d [DEPTH];

  logic              accept;
  logic              ack_ok;
  logic              ack_drop;
  logic              ack_keep;
  logic              pop_ok;
  logic [AWIDTH-1:0] pc_aligned;
  logic [CW:0]       fill_sum;
  logic [CW:0]       flight_sum;
  logic              unused_pc_low;

  assign unused_pc_low = ^pc_i[1:0];

  // Per-cycle bus and consumer events; stray acks with nothing in flight are ignored.
  always_comb begin
    accept     = stb_q & ~bus_stall_i;
    ack_ok     = bus_ack_i & ((outst_q != '0) | (discard_q != '0));
    ack_drop   = ack_ok & (discard_q != '0);
    ack_keep   = ack_ok & (discard_q == '0);
    pop_ok     = pop_i & valid_o;
    pc_aligned = {pc_i[AWIDTH-1:2], 2'b00};
  end

  // Next-state for queue, counters, fetch FSM and the registered strobe decision.
  always_comb begin
    state_d     = state_q;
    fetch_adr_d = fetch_adr_q;
    tail_adr_d  = tail_adr_q;
    count_d     = count_q;
    outst_d     = outst_q;
    discard_d   = discard_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    data_d      = data_q;
    adr_d       = adr_q;

    if (accept) begin
      fetch_adr_d = fetch_adr_q + ADR_STEP;
      outst_d     = outst_q + CNT_ONE;
    end

    // Stale acks always precede live ones, so discard drains first.
    if (ack_drop) begin
      discard_d = discard_q - CNT_ONE;
    end

    if (ack_keep) begin
      outst_d          = outst_d - CNT_ONE;
      data_d[wr_ptr_q] = bus_dat_i;
      adr_d[wr_ptr_q]  = tail_adr_q;
      wr_ptr_d         = wr_ptr_q + PTR_ONE;
      tail_adr_d       = tail_adr_q + ADR_STEP;
      count_d          = count_q + CNT_ONE;
    end

    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d  = count_d - CNT_ONE;
    end

    // Redirect wins over pop and enqueue; every read still on the bus becomes stale.
    if (pc_set_i) begin
      state_d     = ST_FETCH;
      fetch_adr_d = pc_aligned;
      tail_adr_d  = pc_aligned;
      count_d     = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      outst_d     = '0;
      discard_d   = discard_q + outst_q + (accept ? CNT_ONE : '0) - (ack_ok ? CNT_ONE : '0);
    end

    fill_sum   = {1'b0, count_d} + {1'b0, outst_d};
    flight_sum = {1'b0, discard_d} + {1'b0, outst_d};
    stb_d      = (state_d == ST_FETCH) && (fill_sum < DEPTH_W) && (flight_sum < DEPTH_W);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      fetch_adr_q <= '0;
      tail_adr_q  <= '0;
      count_q     <= '0;
      outst_q     <= '0;
      discard_q   <= '0;
      stb_q       <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        adr_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      fetch_adr_q <= fetch_adr_d;
      tail_adr_q  <= tail_adr_d;
      count_q     <= count_d;
      outst_q     <= outst_d;
      discard_q   <= discard_d;
      stb_q       <= stb_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      data_q      <= data_d;
      adr_q       <= adr_d;
    end
  end

  assign valid_o    = (count_q != '0);
  assign word_o     = data_q[rd_ptr_q];
  assign word_adr_o = adr_q[rd_ptr_q];
  assign bus_stb_o  = stb_q;
  assign bus_adr_o  = fetch_adr_q;
  assign bus_cyc_o  = stb_q | (outst_q != '0) | (discard_q != '0);

  ack_protocol_a: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(bus_ack_i && outst_q == '0 && discard_q == '0));

  credit_a: assert property (@(posedge clk_i) disable iff (!rst_i)
    (({1'b0, count_q} + {1'b0, outst_q}) <= DEPTH_W));

endmodule

// File: tb/tb_ins_prefetch.sv
// Bench for ins_prefetch: Wishbone slave model, scoreboard of expected words,
// request-address monitor and directed redirect/stall/reset scenarios.
module tb_ins_prefetch;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        pc_set_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        pop_i = 1'b0;
  logic        valid_o;
  logic [31:0] word_o;
  logic [31:0] word_adr_o;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic [31:0] bus_adr_o;
  logic [31:0] bus_dat_i = '0;
  logic        bus_ack_i = 1'b0;
  logic        bus_stall_i = 1'b0;

  int          checks = 0;
  int          failures = 0;
  int          acc_total = 0;
  logic        slave_hold = 1'b0;
  logic [31:0] pend_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] nxt_adr = '0;

  ins_prefetch #(.DEPTH(DEPTH), .AWIDTH(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pc_set_i    (pc_set_i),
    .pc_i        (pc_i),
    .pop_i       (pop_i),
    .valid_o     (valid_o),
    .word_o      (word_o),
    .word_adr_o  (word_adr_o),
    .bus_cyc_o   (bus_cyc_o),
    .bus_stb_o   (bus_stb_o),
    .bus_adr_o   (bus_adr_o),
    .bus_dat_i   (bus_dat_i),
    .bus_ack_i   (bus_ack_i),
    .bus_stall_i (bus_stall_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0] + 16'h1234};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    pc_set_i = 1'b1;
    pc_i     = pc;
    tick();
    pc_set_i = 1'b0;
  endtask

  task automatic pop_all(input string name);
    int n;
    n = 0;
    pop_i = 1'b1;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    pop_i = 1'b0;
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic quiesce(input string name);
    repeat (12) tick();
    chk(name, {31'd0, bus_cyc_o}, 32'd0);
  endtask

  // Slave model: samples accepts mid-cycle, acks in order one cycle later unless held.
  initial begin : slave
    logic        acc;
    logic [31:0] acc_adr;
    logic [31:0] a;
    forever begin
      @(negedge clk_i);
      acc     = rst_i && bus_cyc_o && bus_stb_o && !bus_stall_i;
      acc_adr = bus_adr_o;
      if (acc) begin
        acc_total++;
        chk("req_adr_sequence", acc_adr, nxt_adr);
        nxt_adr = nxt_adr + 32'd4;
        chk("inflight_le_depth", {31'd0, (32'(pend_q.size()) + 32'd1) <= 32'(DEPTH)}, 32'd1);
      end
      if (rst_i && pc_set_i) nxt_adr = {pc_i[31:2], 2'b00};
      @(posedge clk_i);
      #1;
      if (!rst_i) begin
        pend_q.delete();
        bus_ack_i = 1'b0;
        bus_dat_i = '0;
      end else begin
        if (acc) pend_q.push_back(acc_adr);
        if (!slave_hold && pend_q.size() != 0) begin
          a = pend_q.pop_front();
          bus_ack_i = 1'b1;
          bus_dat_i = mem_fn(a);
        end else begin
          bus_ack_i = 1'b0;
          bus_dat_i = '0;
        end
      end
    end
  end

  // Scoreboard monitor: every word consumed by ifetch must match the next expectation.
  always @(negedge clk_i) begin : word_mon
    logic [31:0] ea;
    if (rst_i && pop_i && valid_o && !pc_set_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop: got word_adr 0x%08h expected no word", word_adr_o);
      end else begin
        ea = exp_q.pop_front();
        chk("pop_word_adr", word_adr_o, ea);
        chk("pop_word_data", word_o, mem_fn(ea));
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    // Reset state.
    tick();
    tick();
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_word", word_o, 32'd0);
    chk("rst_word_adr", word_adr_o, 32'd0);
    chk("rst_cyc", {31'd0, bus_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, bus_stb_o}, 32'd0);
    chk("rst_bus_adr", bus_adr_o, 32'd0);
    rst_i = 1'b1;
    repeat (3) tick();
    chk("idle_stb", {31'd0, bus_stb_o}, 32'd0);
    chk("idle_cyc", {31'd0, bus_cyc_o}, 32'd0);

    // First fill at 0x100 with a zero-wait slave.
    acc_total = 0;
    redirect(32'h100);
    chk("t1_stb_latency", {31'd0, bus_stb_o}, 32'd1);
    chk("t1_first_adr", bus_adr_o, 32'h100);
    chk("t1_cyc", {31'd0, bus_cyc_o}, 32'd1);
    repeat (8) tick();
    chk("t1_accepts", 32'(acc_total), 32'd4);
    chk("t1_stb_dropped", {31'd0, bus_stb_o}, 32'd0);
    chk("t1_cyc_dropped", {31'd0, bus_cyc_o}, 32'd0);
    chk("t1_valid", {31'd0, valid_o}, 32'd1);
    chk("t1_head_adr", word_adr_o, 32'h100);
    chk("t1_head_word", word_o, mem_fn(32'h100));

    // Full queue then continuous popping.
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h100 + 32'(4 * i));
    pop_all("t2_drained");
    quiesce("t2_quiet");

    // Stall three cycles while 0x108 is on the bus.
    redirect(32'h100);
    n = 0;
    while (!(bus_stb_o && bus_adr_o == 32'h108) && n < 20) begin
      tick();
      n++;
    end
    chk("t3_reach_108", bus_adr_o, 32'h108);
    bus_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_adr_held", bus_adr_o, 32'h108);
      chk("t3_stb_held", {31'd0, bus_stb_o}, 32'd1);
    end
    bus_stall_i = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(4 * i));
    pop_all("t3_drained");
    quiesce("t3_quiet");

    // Two reads in flight at 0x110/0x114, then redirect to 0x2002.
    slave_hold = 1'b1;
    redirect(32'h110);
    tick();
    tick();
    bus_stall_i = 1'b1;
    pc_set_i = 1'b1;
    pc_i = 32'h2002;
    tick();
    pc_set_i = 1'b0;
    bus_stall_i = 1'b0;
    chk("t4_stb_new", {31'd0, bus_stb_o}, 32'd1);
    chk("t4_adr_new", bus_adr_o, 32'h2000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_cyc_held", {31'd0, bus_cyc_o}, 32'd1);
    end
    chk("t4_stb_bounded", {31'd0, bus_stb_o}, 32'd0);
    chk("t4_no_valid", {31'd0, valid_o}, 32'd0);
    slave_hold = 1'b0;
    exp_q.push_back(32'h2000);
    exp_q.push_back(32'h2004);
    exp_q.push_back(32'h2008);
    pop_all("t4_drained");
    quiesce("t4_quiet");

    // Redirect coinciding with pop and a live ack.
    redirect(32'h300);
    tick();
    tick();
    pc_set_i = 1'b1;
    pc_i = 32'h400;
    pop_i = 1'b1;
    tick();
    pc_set_i = 1'b0;
    pop_i = 1'b0;
    chk("t5_flushed", {31'd0, valid_o}, 32'd0);
    tick();
    chk("t5_stale_dropped", {31'd0, valid_o}, 32'd0);
    tick();
    chk("t5_valid_new", {31'd0, valid_o}, 32'd1);
    chk("t5_head_adr", word_adr_o, 32'h400);
    exp_q.push_back(32'h400);
    exp_q.push_back(32'h404);
    pop_all("t5_drained");
    quiesce("t5_quiet");

    // Asynchronous reset with three reads outstanding.
    slave_hold = 1'b1;
    redirect(32'h500);
    tick();
    tick();
    tick();
    #2;
    rst_i = 1'b0;
    #1;
    chk("t6_valid", {31'd0, valid_o}, 32'd0);
    chk("t6_word", word_o, 32'd0);
    chk("t6_word_adr", word_adr_o, 32'd0);
    chk("t6_cyc", {31'd0, bus_cyc_o}, 32'd0);
    chk("t6_stb", {31'd0, bus_stb_o}, 32'd0);
    chk("t6_bus_adr", bus_adr_o, 32'd0);
    tick();
    slave_hold = 1'b0;
    tick();
    rst_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_idle_busy", {31'd0, bus_stb_o | bus_cyc_o}, 32'd0);
    end
    redirect(32'h600);
    chk("t6_restart_adr", bus_adr_o, 32'h600);
    exp_q.push_back(32'h600);
    exp_q.push_back(32'h604);
    pop_all("t6_drained");
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
